// File: rtl/hms_time_keeper_pkg.sv
// Shared mode encodings, field limits and decimal-point masks for the
// hour/minute/second time keeper and its display path.
package hms_time_keeper_pkg;

   typedef enum logic [1:0] {
      MODE_CLOCK    = 2'd0,
      MODE_SET_SEC  = 2'd1,
      MODE_SET_MIN  = 2'd2,
      MODE_SET_HOUR = 2'd3
   } mode_e;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [5:0] HOUR_MAX = 6'd23;

   localparam logic [5:0] DP_CLOCK    = 6'b000000;
   localparam logic [5:0] DP_SET_SEC  = 6'b000011;
   localparam logic [5:0] DP_SET_MIN  = 6'b001100;
   localparam logic [5:0] DP_SET_HOUR = 6'b110000;

   // Compare-and-wrap increment used by every time field
   function automatic logic [5:0] wrapInc(input logic [5:0] value, input logic [5:0] maxValue);
      return (value == maxValue) ? 6'd0 : value + 6'd1;
   endfunction

   function automatic logic [5:0] dpForMode(input mode_e mode);
      logic [5:0] mask;
      case (mode)
         MODE_SET_SEC:  mask = DP_SET_SEC;
         MODE_SET_MIN:  mask = DP_SET_MIN;
         MODE_SET_HOUR: mask = DP_SET_HOUR;
         default:       mask = DP_CLOCK;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/hms_time_keeper_btn_pulse.sv
// Push-button conditioner: 2-FF synchronizer, stability-counter debouncer and
// a one-cycle pulse on each debounced press (releases produce nothing).
module hms_time_keeper_btn_pulse #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_pulse;
   logic [CNT_W-1:0] r_count;
   logic             w_differs;
   logic             w_settled;

   // The level flips on the DB_CYCLES-th consecutive disagreeing cycle
   assign w_differs = (r_sync2 != r_level);
   assign w_settled = w_differs && (r_count == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_count <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         if (!w_differs || w_settled) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
         if (w_settled) begin
            r_level <= r_sync2;
         end
         r_pulse <= w_settled && r_sync2;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/hms_time_keeper.sv
// Time-of-day keeper: 1 Hz prescaler, HH:MM:SS counters and a two-button
// set-mode FSM that drives the per-digit decimal-point edit markers.
module hms_time_keeper
   import hms_time_keeper_pkg::*;
#(
   parameter int TICK_DIV  = 50000000,
   parameter int DB_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_mode,
   input  logic       i_btn_inc,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [5:0] o_hour,
   output logic [1:0] o_mode,
   output logic [5:0] o_set_dp,
   output logic       o_tick
);

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic               w_modePulse;
   logic               w_incPulse;
   mode_e              r_mode;
   mode_e              w_modeNext;
   logic [5:0]         w_dpNext;
   logic               w_exitEdit;
   logic [5:0]         r_setDp;
   logic [PRESC_W-1:0] r_presc;
   logic               w_wrap;
   logic               r_tick;
   logic               w_tickApply;
   logic               w_incApply;
   logic [5:0]         r_sec;
   logic [5:0]         r_min;
   logic [5:0]         r_hour;

   hms_time_keeper_btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btnMode (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn_mode),
      .o_pulse (w_modePulse)
   );

   hms_time_keeper_btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btnInc (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn_inc),
      .o_pulse (w_incPulse)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= MODE_CLOCK;
      end else begin
         r_mode <= w_modeNext;
      end
   end

   always_comb begin
      w_modeNext = r_mode;
      if (w_modePulse) begin
         case (r_mode)
            MODE_CLOCK:    w_modeNext = MODE_SET_SEC;
            MODE_SET_SEC:  w_modeNext = MODE_SET_MIN;
            MODE_SET_MIN:  w_modeNext = MODE_SET_HOUR;
            MODE_SET_HOUR: w_modeNext = MODE_CLOCK;
            default:       w_modeNext = MODE_CLOCK;
         endcase
      end
   end

   always_comb begin
      w_dpNext   = dpForMode(w_modeNext);
      w_exitEdit = w_modePulse && (r_mode == MODE_SET_HOUR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_setDp <= DP_CLOCK;
      end else begin
         r_setDp <= w_dpNext;
      end
   end

   // Leaving an edit restarts the prescaler so the first second is full length
   assign w_wrap = (r_presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         if (w_exitEdit || w_wrap) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
         r_tick <= w_wrap;
      end
   end

   // Time only runs in CLOCK mode; a mode press always wins over an increment
   assign w_tickApply = w_wrap && (r_mode == MODE_CLOCK);
   assign w_incApply  = w_incPulse && !w_modePulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sec  <= 6'd0;
         r_min  <= 6'd0;
         r_hour <= 6'd0;
      end else if (w_tickApply) begin
         r_sec <= wrapInc(r_sec, SEC_MAX);
         if (r_sec == SEC_MAX) begin
            r_min <= wrapInc(r_min, MIN_MAX);
            if (r_min == MIN_MAX) begin
               r_hour <= wrapInc(r_hour, HOUR_MAX);
            end
         end
      end else if (w_incApply) begin
         case (r_mode)
            MODE_SET_SEC:  r_sec  <= wrapInc(r_sec, SEC_MAX);
            MODE_SET_MIN:  r_min  <= wrapInc(r_min, MIN_MAX);
            MODE_SET_HOUR: r_hour <= wrapInc(r_hour, HOUR_MAX);
            default:       r_sec  <= r_sec;
         endcase
      end
   end

   assign o_sec    = r_sec;
   assign o_min    = r_min;
   assign o_hour   = r_hour;
   assign o_mode   = r_mode;
   assign o_set_dp = r_setDp;
   assign o_tick   = r_tick;

endmodule

// File: tb/tb_hms_time_keeper.sv
// Directed bench for hms_time_keeper with TICK_DIV=4 and DB_CYCLES=3; all
// expected values are hand-derived cycle counts from the raw button edges.
module tb_hms_time_keeper;

   logic       clk = 1'b0;
   logic       rst;
   logic       btnMode;
   logic       btnInc;
   logic [5:0] sec;
   logic [5:0] min;
   logic [5:0] hour;
   logic [1:0] mode;
   logic [5:0] setDp;
   logic       tick;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hms_time_keeper #(
      .TICK_DIV  (4),
      .DB_CYCLES (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_btn_mode (btnMode),
      .i_btn_inc  (btnInc),
      .o_sec      (sec),
      .o_min      (min),
      .o_hour     (hour),
      .o_mode     (mode),
      .o_set_dp   (setDp),
      .o_tick     (tick)
   );

   // Drive button levels, then advance and settle just after each rising edge
   task automatic applyStimulus(input logic modeLvl, input logic incLvl, input int cycles);
      btnMode = modeLvl;
      btnInc  = incLvl;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Clean press: the mode register moves on the 6th edge after the raw edge
   task automatic pressMode(input logic [1:0] prevMode, input logic [1:0] nextMode, input logic [5:0] nextDp);
      applyStimulus(1'b1, 1'b0, 5);
      checkOutput("mode_before_edge6", {30'd0, mode}, {30'd0, prevMode});
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("mode_at_edge6", {30'd0, mode}, {30'd0, nextMode});
      checkOutput("dp_at_edge6", {26'd0, setDp}, {26'd0, nextDp});
      applyStimulus(1'b1, 1'b0, 4);
      applyStimulus(1'b0, 1'b0, 8);
   endtask

   task automatic pressInc();
      applyStimulus(1'b0, 1'b1, 6);
      applyStimulus(1'b0, 1'b0, 6);
   endtask

   initial begin
      rst     = 1'b1;
      btnMode = 1'b0;
      btnInc  = 1'b0;

      applyStimulus(1'b0, 1'b0, 2);
      checkOutput("rst_sec", {26'd0, sec}, 32'd0);
      checkOutput("rst_min", {26'd0, min}, 32'd0);
      checkOutput("rst_hour", {26'd0, hour}, 32'd0);
      checkOutput("rst_mode", {30'd0, mode}, 32'd0);
      checkOutput("rst_dp", {26'd0, setDp}, 32'd0);
      checkOutput("rst_tick", {31'd0, tick}, 32'd0);
      rst = 1'b0;

      applyStimulus(1'b0, 1'b0, 3);
      checkOutput("tick_edge3", {31'd0, tick}, 32'd0);
      checkOutput("sec_edge3", {26'd0, sec}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("tick_edge4", {31'd0, tick}, 32'd1);
      checkOutput("sec_edge4", {26'd0, sec}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("tick_edge5", {31'd0, tick}, 32'd0);
      checkOutput("sec_edge5", {26'd0, sec}, 32'd1);
      applyStimulus(1'b0, 1'b0, 3);
      checkOutput("sec_edge8", {26'd0, sec}, 32'd2);
      applyStimulus(1'b0, 1'b0, 12);
      checkOutput("sec_edge20", {26'd0, sec}, 32'd5);
      checkOutput("mode_edge20", {30'd0, mode}, 32'd0);
      checkOutput("dp_edge20", {26'd0, setDp}, 32'd0);

      // Mode cycling; tick at edge 24 lands before the edit freezes time
      pressMode(2'd0, 2'd1, 6'b000011);
      checkOutput("sec_frozen_set", {26'd0, sec}, 32'd6);
      pressMode(2'd1, 2'd2, 6'b001100);
      pressMode(2'd2, 2'd3, 6'b110000);
      applyStimulus(1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 5);
      checkOutput("mode_before_exit", {30'd0, mode}, 32'd3);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("mode_exit", {30'd0, mode}, 32'd0);
      checkOutput("dp_exit", {26'd0, setDp}, 32'd0);
      checkOutput("sec_exit", {26'd0, sec}, 32'd6);
      applyStimulus(1'b1, 1'b0, 3);
      checkOutput("tick_exit_plus3", {31'd0, tick}, 32'd0);
      checkOutput("sec_exit_plus3", {26'd0, sec}, 32'd6);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("tick_exit_plus4", {31'd0, tick}, 32'd1);
      checkOutput("sec_exit_plus4", {26'd0, sec}, 32'd7);
      applyStimulus(1'b0, 1'b0, 8);

      // Full rollover from 23:59:59
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 2);
      rst = 1'b0;
      pressMode(2'd0, 2'd1, 6'b000011);
      checkOutput("sec_enter_set", {26'd0, sec}, 32'd1);
      for (int i = 0; i < 58; i++) pressInc();
      checkOutput("sec_set59", {26'd0, sec}, 32'd59);
      checkOutput("min_after_secset", {26'd0, min}, 32'd0);
      pressMode(2'd1, 2'd2, 6'b001100);
      for (int i = 0; i < 59; i++) pressInc();
      checkOutput("min_set59", {26'd0, min}, 32'd59);
      checkOutput("sec_during_minset", {26'd0, sec}, 32'd59);
      checkOutput("hour_after_minset", {26'd0, hour}, 32'd0);
      pressMode(2'd2, 2'd3, 6'b110000);
      for (int i = 0; i < 23; i++) pressInc();
      checkOutput("hour_set23", {26'd0, hour}, 32'd23);
      applyStimulus(1'b1, 1'b0, 6);
      checkOutput("mode_back_clock", {30'd0, mode}, 32'd0);
      applyStimulus(1'b1, 1'b0, 3);
      checkOutput("roll_pre_hour", {26'd0, hour}, 32'd23);
      checkOutput("roll_pre_min", {26'd0, min}, 32'd59);
      checkOutput("roll_pre_sec", {26'd0, sec}, 32'd59);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("roll_tick", {31'd0, tick}, 32'd1);
      checkOutput("roll_hour", {26'd0, hour}, 32'd0);
      checkOutput("roll_min", {26'd0, min}, 32'd0);
      checkOutput("roll_sec", {26'd0, sec}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8);

      // Ticks at +8,+12,+16 count before SET_SEC is entered at +18
      pressMode(2'd0, 2'd1, 6'b000011);
      checkOutput("sec_second_edit", {26'd0, sec}, 32'd3);
      pressMode(2'd1, 2'd2, 6'b001100);
      pressMode(2'd2, 2'd3, 6'b110000);
      for (int i = 0; i < 5; i++) pressInc();
      checkOutput("hour_set5", {26'd0, hour}, 32'd5);
      pressMode(2'd3, 2'd0, 6'b000000);
      pressMode(2'd0, 2'd1, 6'b000011);
      checkOutput("sec_third_edit", {26'd0, sec}, 32'd7);

      // Simultaneous mode and inc edges: the increment is dropped
      applyStimulus(1'b1, 1'b1, 5);
      checkOutput("simul_mode_before", {30'd0, mode}, 32'd1);
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput("simul_mode", {30'd0, mode}, 32'd2);
      checkOutput("simul_dp", {26'd0, setDp}, 32'b001100);
      checkOutput("simul_sec", {26'd0, sec}, 32'd7);
      applyStimulus(1'b1, 1'b1, 4);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("simul_sec_later", {26'd0, sec}, 32'd7);
      checkOutput("simul_min_later", {26'd0, min}, 32'd0);

      // Minute wrap inside SET_MIN must not carry into the hour
      for (int i = 0; i < 59; i++) pressInc();
      checkOutput("minwrap_pre_min", {26'd0, min}, 32'd59);
      pressInc();
      checkOutput("minwrap_min", {26'd0, min}, 32'd0);
      checkOutput("minwrap_hour", {26'd0, hour}, 32'd5);
      checkOutput("minwrap_sec", {26'd0, sec}, 32'd7);

      // Reset mid-edit
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("midrst_mode", {30'd0, mode}, 32'd0);
      checkOutput("midrst_dp", {26'd0, setDp}, 32'd0);
      checkOutput("midrst_sec", {26'd0, sec}, 32'd0);
      checkOutput("midrst_min", {26'd0, min}, 32'd0);
      checkOutput("midrst_hour", {26'd0, hour}, 32'd0);
      rst = 1'b0;

      // Bounce rejection, then one clean hold
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 2);
         applyStimulus(1'b0, 1'b0, 2);
      end
      checkOutput("bounce_mode", {30'd0, mode}, 32'd0);
      checkOutput("bounce_dp", {26'd0, setDp}, 32'd0);
      applyStimulus(1'b1, 1'b0, 5);
      checkOutput("hold_mode_before", {30'd0, mode}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("hold_mode", {30'd0, mode}, 32'd1);
      checkOutput("hold_dp", {26'd0, setDp}, 32'b000011);
      applyStimulus(1'b1, 1'b0, 4);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("hold_single", {30'd0, mode}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
